prbs_checker: RTL and testbench
===============================

# prbs_checker

Receive-side checker for the 4-bit PRBS stream (polynomial x^4+x^3+1, period 15) that our generator emits one bit per clock. It self-synchronises to the incoming bit stream and declares lock. Once locked, it flywheels on its own predicted sequence and counts bit errors and checked bits. It sits at the far end of the pattern link, between the channel/detector under test and the status registers.

## Interface
- LOCK_COUNT, 8: consecutive correct predictions needed in ACQUIRE to declare lock (1–15).
- LOSS_THRESH, 4: mismatches in LOCKED without an intervening clean 15-bit run that force relock (1–15).
- CNT_W, 16: width of err_count and bit_count.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- rx_bit  in  1  received PRBS bit; sampled only when rx_valid=1.
- rx_valid  in  1  qualifies rx_bit; may be low any number of cycles.
- clear_counts  in  1  synchronous clear of err_count and bit_count; does not affect lock.
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED.

## Operation
- History register h[3:0]: h[0] is the newest bit and h[3] is 4 bits old. Prediction p = h[3]^h[2]. On every accepted bit, h <= {h[2:0], x}.
- FSM states SEED, ACQUIRE, LOCKED. Reset enters SEED.
- SEED: shift rx_bit into h with no checking. After 4 accepted bits, go to ACQUIRE (seed_cnt 0..3).
- ACQUIRE:
  - Shift rx_bit into h (self-sync). Compare rx_bit against p.
  - A match with h≠0 increments good_run. A mismatch, or h==4'b0000 (lockup pattern), clears good_run to 0.
  - When the match brings good_run to LOCK_COUNT, go to LOCKED and clear miss_cnt and clean_run.
- LOCKED:
  - Shift p, not rx_bit, into h (flywheel), so an isolated error does not corrupt later predictions.
  - Every accepted bit increments bit_count.
  - A mismatch increments err_count, pulses err_pulse, increments miss_cnt, and clears clean_run.
  - A match increments clean_run. When clean_run reaches 15, clear miss_cnt and clean_run.
  - When miss_cnt reaches LOSS_THRESH, go to SEED, clear good_run and seed_cnt, and drop locked. err_count still counts that final error.
- Counters saturate at 2^CNT_W−1 and never wrap. They change only in LOCKED.
- clear_counts: both counters become 0 on the next edge. If clear_counts and an increment coincide, clear wins and the result is 0.
- rx_valid=0: no state, history or counter changes, and err_pulse=0.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, bit_count=0, h=0, state=SEED, all internal counters 0.
- All outputs are registered.
- err_pulse and the err_count/bit_count updates appear on the edge that samples the valid bit, visible the following cycle.
- locked rises on the edge sampling the LOCK_COUNT-th consecutive good bit. With gap-free input after reset, that is 4+LOCK_COUNT valid bits (12 by default).
- locked falls on the edge sampling the LOSS_THRESH-th qualifying mismatch.
- Reset asserted mid-stream returns to SEED immediately (asynchronous) and clears counts. There is no partial-lock carry-over.
- Throughput: one bit per clock, no back-pressure.

## Test plan
- Gap-free input after reset, stream 1,1,1,0,0,0,1,0,0,1,1,0,1,0,1 repeating, defaults -> locked=1 after bit 12; err_count=0; bit_count=303 after 315 total bits.
- Same stream with rx_valid toggling 1,0,1,0 -> lock after 12 valid bits (24 cycles); counters advance only on valid cycles; no err_pulse.
- Once locked, flip one bit every 20 bits, 5 times -> err_pulse fires 5 times, err_count=5; flywheel keeps locked=1, with no follow-on errors from corrupted history.
- Once locked, flip 4 bits within one 15-bit window -> err_count=4, locked falls on the 4th error; a clean stream relocks 12 valid bits later.
- All-zero input for 40 bits -> never locks; err_count=0 and bit_count=0.
- CNT_W=4, locked, continuous errors with LOSS_THRESH=15 -> err_count saturates at 15; clear_counts asserted together with an error -> err_count=0 next cycle.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the x^4+x^3+1 (period 15) PRBS stream.
// It self-synchronises to the incoming bits, declares lock, then flywheels on its
// own predicted sequence while counting checked bits and bit errors.
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   reset        in   asynchronous, active-high
//   rx_bit       in   received PRBS bit, sampled only when rx_valid=1
//   rx_valid     in   qualifies rx_bit
//   clear_counts in   synchronous clear of err_count and bit_count (lock unaffected)
//   locked       out  checker is in LOCKED
//   err_pulse    out  one-cycle pulse per mismatched bit while LOCKED
//   err_count    out  saturating mismatch count while LOCKED
//   bit_count    out  saturating count of valid bits checked while LOCKED
module prbs_checker #(
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_N  = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOSS_N  = RUN_W'(LOSS_THRESH);
  localparam logic [RUN_W-1:0] CLEAN_N = RUN_W'(15);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       h;          // h[0] newest, h[3] four bits old
  logic [1:0]       seed_cnt;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] miss_cnt;
  logic [RUN_W-1:0] clean_run;

  logic pred_c;
  logic match_c;

  // Next bit of the sequence predicted from history
  assign pred_c  = h[3] ^ h[2];
  assign match_c = (rx_bit == pred_c);

  // Sync/lock FSM, history register and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEED;
      h         <= 4'b0000;
      seed_cnt  <= 2'd0;
      good_run  <= '0;
      miss_cnt  <= '0;
      clean_run <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;

      if (rx_valid) begin
        case (state)
          SEED: begin
            h <= {h[2:0], rx_bit};
            if (seed_cnt == 2'd3) begin
              seed_cnt <= 2'd0;
              state    <= ACQUIRE;
            end else begin
              seed_cnt <= seed_cnt + 2'd1;
            end
          end

          ACQUIRE: begin
            h <= {h[2:0], rx_bit};
            // An all-zero history is the LFSR lockup pattern and never counts as good
            if (match_c && (h != 4'b0000)) begin
              if ((good_run + RUN_W'(1)) == LOCK_N) begin
                good_run  <= '0;
                miss_cnt  <= '0;
                clean_run <= '0;
                locked    <= 1'b1;
                state     <= LOCKED;
              end else begin
                good_run <= good_run + RUN_W'(1);
              end
            end else begin
              good_run <= '0;
            end
          end

          LOCKED: begin
            // Flywheel: shift the prediction so a bad bit cannot poison later predictions
            h <= {h[2:0], pred_c};
            if (bit_count != CNT_MAX) begin
              bit_count <= bit_count + CNT_W'(1);
            end
            if (!match_c) begin
              err_pulse <= 1'b1;
              if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
              end
              clean_run <= '0;
              if ((miss_cnt + RUN_W'(1)) == LOSS_N) begin
                miss_cnt <= '0;
                good_run <= '0;
                seed_cnt <= 2'd0;
                locked   <= 1'b0;
                state    <= SEED;
              end else begin
                miss_cnt <= miss_cnt + RUN_W'(1);
              end
            end else if ((clean_run + RUN_W'(1)) == CLEAN_N) begin
              // A full clean period forgives earlier isolated misses
              clean_run <= '0;
              miss_cnt  <= '0;
            end else begin
              clean_run <= clean_run + RUN_W'(1);
            end
          end

          default: begin
            state  <= SEED;
            locked <= 1'b0;
          end
        endcase
      end

      // Placed last so a coincident increment loses to the clear
      if (clear_counts) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scoreboard bench for prbs_checker.
// Instance d0 uses default parameters; d1 uses CNT_W=4, LOSS_THRESH=15 for
// saturation. Stimulus pushes the hand-derived expected outputs for each cycle;
// a monitor pops and compares them one step after each rising edge.
module tb_prbs_checker;

  typedef struct {
    bit    lk;
    bit    pl;
    int    ec;
    int    bc;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rb0 = 1'b0, rv0 = 1'b0, cc0 = 1'b0;
  logic rb1 = 1'b0, rv1 = 1'b0, cc1 = 1'b0;
  logic        lk0, pl0, lk1, pl1;
  logic [15:0] ec0, bc0;
  logic [3:0]  ec1, bc1;

  exp_t  q0[$];
  exp_t  q1[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag = "reset";

  bit pat[15] = '{1,1,1,0,0,0,1,0,0,1,1,0,1,0,1};
  int sp = 0;

  bit e_lk[2];
  int e_ec[2];
  int e_bc[2];
  int cmax[2] = '{65535, 15};

  always #5 clk = ~clk;

  prbs_checker d0 (
    .clk(clk), .reset(reset), .rx_bit(rb0), .rx_valid(rv0), .clear_counts(cc0),
    .locked(lk0), .err_pulse(pl0), .err_count(ec0), .bit_count(bc0)
  );

  prbs_checker #(.LOCK_COUNT(8), .LOSS_THRESH(15), .CNT_W(4)) d1 (
    .clk(clk), .reset(reset), .rx_bit(rb1), .rx_valid(rv1), .clear_counts(cc1),
    .locked(lk1), .err_pulse(pl1), .err_count(ec1), .bit_count(bc1)
  );

  // Drive one cycle on instance id and queue what it must show after the edge
  task automatic send(input int id, input bit x, input bit v, input bit clr,
                      input bit lk_after, input bit pl);
    exp_t it;
    @(negedge clk);
    rv0 = 1'b0; cc0 = 1'b0; rv1 = 1'b0; cc1 = 1'b0;
    if (id == 0) begin rb0 = x; rv0 = v; cc0 = clr; end
    else         begin rb1 = x; rv1 = v; cc1 = clr; end
    if (clr) begin
      e_ec[id] = 0;
      e_bc[id] = 0;
    end else if (v && e_lk[id]) begin
      if (e_bc[id] < cmax[id]) e_bc[id]++;
      if (pl && e_ec[id] < cmax[id]) e_ec[id]++;
    end
    e_lk[id] = lk_after;
    it.lk = lk_after; it.pl = pl; it.ec = e_ec[id]; it.bc = e_bc[id]; it.tag = cur_tag;
    if (id == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic stream_bit(input int id, input bit flip, input bit clr,
                            input bit lk_after, input bit pl);
    bit x;
    x = pat[sp] ^ flip;
    sp = (sp + 1) % 15;
    send(id, x, 1'b1, clr, lk_after, pl);
  endtask

  task automatic idle(input int id);
    send(id, 1'b0, 1'b0, 1'b0, e_lk[id], 1'b0);
  endtask

  task automatic do_reset();
    exp_t it;
    @(negedge clk);
    reset = 1'b1;
    rv0 = 1'b0; cc0 = 1'b0; rv1 = 1'b0; cc1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_lk[i] = 1'b0; e_ec[i] = 0; e_bc[i] = 0;
    end
    it.lk = 1'b0; it.pl = 1'b0; it.ec = 0; it.bc = 0; it.tag = {cur_tag, "_rst"};
    q0.push_back(it);
    q1.push_back(it);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare every queued expectation just after the edge it belongs to
  always @(posedge clk) begin
    exp_t it;
    #1;
    if (q0.size() != 0) begin
      it = q0.pop_front();
      n_checks++;
      if (lk0 !== it.lk || pl0 !== it.pl || 32'(ec0) !== 32'(it.ec) || 32'(bc0) !== 32'(it.bc)) begin
        n_errors++;
        $display("FAIL d0 %s: got lock=%0b pulse=%0b err=%0d bits=%0d, want lock=%0b pulse=%0b err=%0d bits=%0d",
                 it.tag, lk0, pl0, ec0, bc0, it.lk, it.pl, it.ec, it.bc);
      end
    end
    if (q1.size() != 0) begin
      it = q1.pop_front();
      n_checks++;
      if (lk1 !== it.lk || pl1 !== it.pl || 32'(ec1) !== 32'(it.ec) || 32'(bc1) !== 32'(it.bc)) begin
        n_errors++;
        $display("FAIL d1 %s: got lock=%0b pulse=%0b err=%0d bits=%0d, want lock=%0b pulse=%0b err=%0d bits=%0d",
                 it.tag, lk1, pl1, ec1, bc1, it.lk, it.pl, it.ec, it.bc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_lk[i] = 1'b0; e_ec[i] = 0; e_bc[i] = 0;
    end

    // Gap-free stream: lock on valid bit 12, 303 bits checked after 315
    cur_tag = "gapfree";
    do_reset();
    for (int n = 1; n <= 315; n++) stream_bit(0, 1'b0, 1'b0, n >= 12, 1'b0);

    // rx_valid toggling: lock on the 12th valid bit, idle cycles change nothing
    cur_tag = "toggle";
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      stream_bit(0, 1'b0, 1'b0, n >= 12, 1'b0);
      idle(0);
    end

    // Isolated errors every 20 bits: flywheel keeps lock, no follow-on errors
    cur_tag = "isolated";
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 19; n++) stream_bit(0, 1'b0, 1'b0, 1'b1, 1'b0);
      stream_bit(0, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    for (int n = 0; n < 20; n++) stream_bit(0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Four errors within one window: lock drops on the 4th, relock 12 valid bits later
    cur_tag = "loss";
    for (int k = 0; k < 7; k++) stream_bit(0, (k % 2) == 0, 1'b0, k != 6, (k % 2) == 0);
    cur_tag = "relock";
    for (int n = 1; n <= 14; n++) stream_bit(0, 1'b0, 1'b0, n >= 12, 1'b0);
    cur_tag = "clear";
    stream_bit(0, 1'b0, 1'b1, 1'b1, 1'b0);
    stream_bit(0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset, then all-zero input never locks
    cur_tag = "zeros";
    do_reset();
    for (int n = 0; n < 40; n++) send(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4-bit counters: saturation and clear beating a coincident error
    cur_tag = "sat_lock";
    do_reset();
    for (int n = 1; n <= 12; n++) stream_bit(1, 1'b0, 1'b0, n >= 12, 1'b0);
    cur_tag = "sat_err";
    for (int n = 0; n < 10; n++) stream_bit(1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 15; n++) stream_bit(1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) stream_bit(1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 15; n++) stream_bit(1, 1'b0, 1'b0, 1'b1, 1'b0);
    cur_tag = "sat_clear";
    stream_bit(1, 1'b1, 1'b1, 1'b1, 1'b1);
    stream_bit(1, 1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    rv0 = 1'b0; rv1 = 1'b0; cc0 = 1'b0; cc1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
